echo_sample_frontend: RTL and testbench
=======================================

// Module: echo_sample_frontend
// PURPOSE
//   Upstream feeder for the echo-cancellation datapath. Accepts signed fixed-point
//   send/receive sample pairs and converts each to IEEE-754 double, exactly and with
//   a multi-cycle normaliser. Generates the per-sample cycle counter and publishes
//   each pair on a sample boundary, with enable_sampling/enable strobes to the canceller.
//   Flags input overrun and a canceller that is still busy when the next sample is due.
// PARAMETERS
//   SAMPLE_PERIOD  250  clk_operation cycles per sample; legal range 20..8191
//   IN_WIDTH       16   width of the signed two's-complement input samples
// PORTS
//   clk_operation           in   1         operation clock
//   rst                     in   1         synchronous, active-high reset
//   sample_valid_in         in   1         input pair valid
//   send_sample             in   IN_WIDTH  far-end (sent) sample, signed
//   receive_sample          in   IN_WIDTH  near-end (received) sample, signed
//   sample_ready_out        out  1         pair accepted when valid & ready
//   cancel_ready            in   1         canceller ready (result done)
//   signal_send             out  64        published send sample, IEEE-754 double
//   signal_receive          out  64        published receive sample, IEEE-754 double
//   sampling_cycle_counter  out  13        phase within sample period, 0..SAMPLE_PERIOD-1
//   enable_sampling         out  1         fresh pair present; high in cycle counter==0
//   enable                  out  1         one-cycle start pulse in cycle counter==1
//   overrun                 out  1         sticky: valid seen while not ready
//   late                    out  1         sticky: publish while canceller busy
// BEHAVIOUR
// - Reset values: all outputs 0; cycle_cnt 0; FSM state IDLE.
// - sample_ready_out = (state==IDLE) & ~rst.
// - Reset mid-conversion aborts the conversion and drops the pair.
// - Counter:
//   - cycle_cnt increments every clock.
//   - Wraps SAMPLE_PERIOD-1 -> 0.
//   - sampling_cycle_counter = cycle_cnt.
// - FSM:
//   - IDLE: on valid&ready, capture both samples -> CONV.
//   - CONV: per channel, sign=x[MSB]; mag=|x| (IN_WIDTH-bit unsigned, so -2^(IN_WIDTH-1) is exact).
//     - Shift mag left 1 bit/cycle until its MSB is set, counting shifts s.
//     - Both channels shift in parallel; a channel with mag==0 is done immediately.
//     - -> PACK when both are done.
//   - PACK (1 cycle): build each double.
//     - Nonzero: exp = 1023 + (IN_WIDTH-1-s); mantissa = shifted mag minus its MSB, left-aligned in 52 bits.
//     - Zero input: 64'h0.
//     - No rounding is needed. -> DONE.
//   - DONE: hold the pair. At the edge where cycle_cnt goes SAMPLE_PERIOD-1 -> 0:
//     - signal_send/receive <= converted pair;
//     - enable_sampling <= 1 for exactly one cycle;
//     - -> IDLE.
// - Conversion latency from acceptance to DONE is at most IN_WIDTH+2 cycles.
//   - Publish occurs at the first wrap after DONE.
//   - Worst-case accept-to-publish is 2*SAMPLE_PERIOD.
// - enable:
//   - Registered one-cycle pulse during cycle_cnt==1, following a publish.
//   - Suppressed, and late set, if cancel_ready==0 at that edge and an enable has already been issued since reset.
//   - The first enable after reset is always issued.
// - signal_send/receive hold their value between publishes and change only on the wrap edge.
//   They are therefore stable whenever the canceller samples at counter==0.
// - overrun:
//   - Set when sample_valid_in & ~sample_ready_out.
//   - The offered pair is ignored.
//   - Cleared only by rst.
// - If no pair is in DONE at the wrap, nothing is published: enable_sampling and enable stay 0.
// TESTING
//   1. send=1, recv=-2 -> signal_send=64'h3FF0000000000000, signal_receive=64'hC000000000000000,
//      enable_sampling high for one cycle at counter 0, then enable high at counter 1.
//   2. send=0, recv=-32768 -> 64'h0000000000000000, 64'hC0E0000000000000.
//   3. send=32767, recv=3 -> 64'h40DFFFC000000000, 64'h4008000000000000.
//   4. valid held high continuously -> one pair accepted per period; overrun=1;
//      outputs change only at wraps.
//   5. cancel_ready=0 at second publish -> no enable pulse, late=1, signal_* still updated.
//   6. rst asserted 5 cycles into CONV -> all outputs 0, no publish at next wrap,
//      counter restarts at 0; a new pair converts normally.

Source files
------------

// File: rtl/echo_sample_frontend.sv
// Front end for the echo canceller: accepts signed sample pairs, converts them to
// IEEE-754 doubles with a shift normaliser and publishes them on sample-period wraps.
module echo_sample_frontend #(
  parameter int unsigned SAMPLE_PERIOD = 250,
  parameter int unsigned IN_WIDTH      = 16
) (
  input  logic                clk_operation,
  input  logic                rst,
  input  logic                sample_valid_in,
  input  logic [IN_WIDTH-1:0] send_sample,
  input  logic [IN_WIDTH-1:0] receive_sample,
  output logic                sample_ready_out,
  input  logic                cancel_ready,
  output logic [63:0]         signal_send,
  output logic [63:0]         signal_receive,
  output logic [12:0]         sampling_cycle_counter,
  output logic                enable_sampling,
  output logic                enable,
  output logic                overrun,
  output logic                late
);

  localparam int unsigned SW   = $clog2(IN_WIDTH);
  localparam int unsigned MPAD = 53 - IN_WIDTH;
  localparam logic [12:0] LAST = 13'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, CONV, PACK, DONE} state_t;

  state_t              state;
  logic [12:0]         cycle_cnt;
  logic [IN_WIDTH-1:0] mag_send, mag_recv;
  logic [SW-1:0]       sh_send, sh_recv;
  logic                neg_send, neg_recv;
  logic [63:0]         conv_send, conv_recv;
  logic                enable_issued;
  logic                send_done, recv_done;

  function automatic logic [IN_WIDTH-1:0] magnitude(input logic [IN_WIDTH-1:0] x);
    logic [IN_WIDTH-1:0] r;
    r = x[IN_WIDTH-1] ? (~x + 1'b1) : x;
    return r;
  endfunction

  // Normalised magnitude: the leading one becomes the implicit bit and is dropped.
  function automatic logic [63:0] pack(input logic neg, input logic [IN_WIDTH-1:0] m,
                                       input logic [SW-1:0] s);
    logic [10:0] e;
    e = 11'(1023 + IN_WIDTH - 1) - 11'(s);
    if (m == '0) return '0;
    return {neg, e, m[IN_WIDTH-2:0], {MPAD{1'b0}}};
  endfunction

  assign sample_ready_out       = (state == IDLE) & ~rst;
  assign sampling_cycle_counter = cycle_cnt;
  assign send_done              = mag_send[IN_WIDTH-1] | (mag_send == '0);
  assign recv_done              = mag_recv[IN_WIDTH-1] | (mag_recv == '0);

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state           <= IDLE;
      cycle_cnt       <= '0;
      mag_send        <= '0;
      mag_recv        <= '0;
      sh_send         <= '0;
      sh_recv         <= '0;
      neg_send        <= 1'b0;
      neg_recv        <= 1'b0;
      conv_send       <= '0;
      conv_recv       <= '0;
      enable_issued   <= 1'b0;
      signal_send     <= '0;
      signal_receive  <= '0;
      enable_sampling <= 1'b0;
      enable          <= 1'b0;
      overrun         <= 1'b0;
      late            <= 1'b0;
    end else begin
      cycle_cnt       <= (cycle_cnt == LAST) ? '0 : cycle_cnt + 1'b1;
      enable_sampling <= 1'b0;
      enable          <= 1'b0;

      if (sample_valid_in && !sample_ready_out) overrun <= 1'b1;

      // enable_sampling is high exactly in the counter==0 cycle after a publish.
      if (enable_sampling) begin
        if (cancel_ready || !enable_issued) begin
          enable        <= 1'b1;
          enable_issued <= 1'b1;
        end else begin
          late <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (sample_valid_in) begin
            neg_send <= send_sample[IN_WIDTH-1];
            neg_recv <= receive_sample[IN_WIDTH-1];
            mag_send <= magnitude(send_sample);
            mag_recv <= magnitude(receive_sample);
            sh_send  <= '0;
            sh_recv  <= '0;
            state    <= CONV;
          end
        end
        CONV: begin
          if (send_done && recv_done) state <= PACK;
          if (!send_done) begin
            mag_send <= mag_send << 1;
            sh_send  <= sh_send + 1'b1;
          end
          if (!recv_done) begin
            mag_recv <= mag_recv << 1;
            sh_recv  <= sh_recv + 1'b1;
          end
        end
        PACK: begin
          conv_send <= pack(neg_send, mag_send, sh_send);
          conv_recv <= pack(neg_recv, mag_recv, sh_recv);
          state     <= DONE;
        end
        DONE: begin
          if (cycle_cnt == LAST) begin
            signal_send     <= conv_send;
            signal_receive  <= conv_recv;
            enable_sampling <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_sample_frontend.sv
// Randomised self-checking bench for echo_sample_frontend; conversions are checked
// against the simulator's own integer-to-double conversion.
module tb_echo_sample_frontend;

  localparam int unsigned SP = 40;

  logic        clk_operation = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid_in = 1'b0;
  logic [15:0] send_sample = '0;
  logic [15:0] receive_sample = '0;
  logic        sample_ready_out;
  logic        cancel_ready = 1'b1;
  logic [63:0] signal_send, signal_receive;
  logic [12:0] sampling_cycle_counter;
  logic        enable_sampling, enable, overrun, late;

  echo_sample_frontend #(.SAMPLE_PERIOD(SP), .IN_WIDTH(16)) dut (
    .clk_operation(clk_operation), .rst(rst),
    .sample_valid_in(sample_valid_in), .send_sample(send_sample),
    .receive_sample(receive_sample), .sample_ready_out(sample_ready_out),
    .cancel_ready(cancel_ready), .signal_send(signal_send),
    .signal_receive(signal_receive), .sampling_cycle_counter(sampling_cycle_counter),
    .enable_sampling(enable_sampling), .enable(enable), .overrun(overrun), .late(late)
  );

  always #5 clk_operation = ~clk_operation;

  // Reference phase within the sample period.
  int unsigned tcnt = 0;
  always @(posedge clk_operation) begin
    if (rst) tcnt <= 0;
    else     tcnt <= (tcnt == SP - 1) ? 0 : tcnt + 1;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] last_send = '0, last_recv = '0;
  logic        issued = 1'b0, exp_late = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] to_double(input logic [15:0] x);
    return $realtobits($itor($signed(x)));
  endfunction

  task automatic wait_phase(input int unsigned p);
    int unsigned n = 0;
    @(negedge clk_operation);
    while (tcnt != p && n < 4 * SP) begin
      @(negedge clk_operation);
      n++;
    end
    if (tcnt != p) check("phase_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_send", signal_send, 64'd0);
    check("rst_recv", signal_receive, 64'd0);
    check("rst_cnt", 64'(sampling_cycle_counter), 64'd0);
    check("rst_es", 64'(enable_sampling), 64'd0);
    check("rst_en", 64'(enable), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_late", 64'(late), 64'd0);
    check("rst_ready", 64'(sample_ready_out), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid_in = 1'b0;
    @(negedge clk_operation);
    check_reset_outputs();
    rst = 1'b0;
    last_send = '0; last_recv = '0; issued = 1'b0; exp_late = 1'b0;
  endtask

  task automatic offer(input logic [15:0] s, input logic [15:0] r);
    check("ready", 64'(sample_ready_out), 64'd1);
    sample_valid_in = 1'b1; send_sample = s; receive_sample = r;
    @(negedge clk_operation);
    sample_valid_in = 1'b0;
    send_sample = 16'($urandom); receive_sample = 16'($urandom);
  endtask

  // Waits for the next wrap and checks the publish plus the enable/late handshake.
  task automatic publish_check(input logic [63:0] es, input logic [63:0] er, input logic cr);
    logic exp_en;
    cancel_ready = cr;
    wait_phase(SP - 1);
    check("hold_send", signal_send, last_send);
    check("hold_recv", signal_receive, last_recv);
    check("es_idle", 64'(enable_sampling), 64'd0);
    wait_phase(0);
    check("cnt0", 64'(sampling_cycle_counter), 64'd0);
    check("es_pulse", 64'(enable_sampling), 64'd1);
    check("pub_send", signal_send, es);
    check("pub_recv", signal_receive, er);
    last_send = es; last_recv = er;
    exp_en = cr | ~issued;
    if (exp_en) issued = 1'b1; else exp_late = 1'b1;
    wait_phase(1);
    check("cnt1", 64'(sampling_cycle_counter), 64'd1);
    check("enable", 64'(enable), 64'(exp_en));
    check("es_off", 64'(enable_sampling), 64'd0);
    check("late", 64'(late), 64'(exp_late));
    wait_phase(2);
    check("enable_off", 64'(enable), 64'd0);
    cancel_ready = 1'b1;
  endtask

  task automatic run_pair(input logic [15:0] s, input logic [15:0] r,
                          input logic [63:0] es, input logic [63:0] er, input logic cr);
    offer(s, r);
    publish_check(es, er, cr);
  endtask

  initial begin
    logic [63:0] pend_s, pend_r;
    logic [15:0] rs, rr;

    repeat (3) @(negedge clk_operation);
    check_reset_outputs();
    rst = 1'b0;
    wait_phase(2);

    run_pair(16'd1, 16'hFFFE, 64'h3FF0000000000000, 64'hC000000000000000, 1'b1);
    run_pair(16'd0, 16'h8000, 64'h0000000000000000, 64'hC0E0000000000000, 1'b1);
    run_pair(16'h7FFF, 16'd3, 64'h40DFFFC000000000, 64'h4008000000000000, 1'b1);
    // Canceller busy at this publish: enable suppressed, late raised, data still updated.
    run_pair(16'd100, 16'hFF9C, to_double(16'd100), to_double(16'hFF9C), 1'b0);
    check("overrun_clear", 64'(overrun), 64'd0);

    // Valid held high: exactly one pair per period is accepted.
    sample_valid_in = 1'b1;
    send_sample = 16'($urandom); receive_sample = 16'($urandom);
    pend_s = to_double(send_sample); pend_r = to_double(receive_sample);
    for (int k = 0; k < 3; k++) begin
      wait_phase(SP - 1);
      check("hold_hs", signal_send, last_send);
      check("hold_hr", signal_receive, last_recv);
      check("overrun_set", 64'(overrun), 64'd1);
      check("ready_busy", 64'(sample_ready_out), 64'd0);
      wait_phase(0);
      check("hold_es", 64'(enable_sampling), 64'd1);
      check("hold_pub_s", signal_send, pend_s);
      check("hold_pub_r", signal_receive, pend_r);
      last_send = pend_s; last_recv = pend_r; issued = 1'b1;
      send_sample = 16'($urandom); receive_sample = 16'($urandom);
      pend_s = to_double(send_sample); pend_r = to_double(receive_sample);
      wait_phase(1);
      check("hold_en", 64'(enable), 64'd1);
      send_sample = 16'($urandom); receive_sample = 16'($urandom);
      if (k == 2) sample_valid_in = 1'b0;
    end
    publish_check(pend_s, pend_r, 1'b1);

    // Reset during conversion drops the pair.
    offer(16'd1, 16'd1);
    repeat (4) @(negedge clk_operation);
    do_reset();
    wait_phase(0);
    check("nopub_es", 64'(enable_sampling), 64'd0);
    check("nopub_send", signal_send, 64'd0);
    wait_phase(1);
    check("nopub_en", 64'(enable), 64'd0);
    wait_phase(2);
    // First enable after reset is issued even with the canceller busy.
    run_pair(16'hFFFF, 16'd2, 64'hBFF0000000000000, 64'h4000000000000000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rs = 16'($urandom);
      rr = 16'($urandom);
      if (i == 0) rs = 16'h8000;
      if (i == 1) rr = 16'h0000;
      run_pair(rs, rr, to_double(rs), to_double(rr), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
